// File: rtl/register_mode_cfg_pkg.sv
// Shared types and constants for the RegisterMode configuration front-end.
// Optional readback is enabled by defining REGISTER_MODE_CFG_READBACK_EN.
package register_mode_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1
`ifdef REGISTER_MODE_CFG_READBACK_EN
        ,
        ST_READ = 2'd2
`endif
    } state_t;

    localparam logic [1:0] OFF_MODE   = 2'd0;
    localparam logic [1:0] OFF_CONST  = 2'd1;
    localparam logic [1:0] OFF_VALUE  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam logic [1:0] MODE_CONST  = 2'd0;
    localparam logic [1:0] MODE_BYPASS = 2'd1;
    localparam logic [1:0] MODE_DELAY  = 2'd2;

endpackage

// File: rtl/register_mode_cfg_sat_counter8.sv
// 8-bit saturating event counter with synchronous active-low clear.
module sat_counter8 (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       inc,
    output logic [7:0] count
);

    // Clear dominates; otherwise count up and stick at 255.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/register_mode_cfg.sv
// Configuration front-end for the RegisterMode tile register: decodes an
// addressed valid/ready bus into mode/const settings and config_we pulses.
// Define REGISTER_MODE_CFG_READBACK_EN to enable reads and the load counter.
module register_mode_cfg
    import register_mode_cfg_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_write,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0]      cfg_wdata,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  stall,
    input  logic [WIDTH-1:0]      reg_value,
    output logic [1:0]            mode,
    output logic [WIDTH-1:0]      const_,
    output logic                  clk_en,
    output logic                  config_we,
    output logic [WIDTH-1:0]      config_data
);

    typedef logic [ADDR_WIDTH:0] addr_ext_t;
    localparam addr_ext_t BASE_EXT = addr_ext_t'(BASE_ADDR);

    state_t    state;
    addr_ext_t rel_addr;
    logic      in_range;
    logic [1:0] offset;
    logic      handshake;

    // Address decode: one extra bit so addresses below the base wrap out of range.
    always_comb begin
        rel_addr  = {1'b0, cfg_addr} - BASE_EXT;
        in_range  = (rel_addr[ADDR_WIDTH:2] == '0);
        offset    = rel_addr[1:0];
        handshake = cfg_valid && cfg_ready;
    end

    // Tile clock enable is stall inverted, one cycle late.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            clk_en <= 1'b0;
        end else begin
            clk_en <= ~stall;
        end
    end

`ifdef REGISTER_MODE_CFG_READBACK_EN
    logic       rd_valid_r;
    logic [2:0] rd_sel;
    logic [7:0] load_count;

    sat_counter8 u_load_counter (
        .clk     (CLK),
        .clear_n (RESETN),
        .inc     (state == ST_LOAD),
        .count   (load_count)
    );
`else
    logic unused_reg_value;
    assign unused_reg_value = ^reg_value;
`endif

    // Transaction FSM with registered handshake and pulse outputs.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state       <= ST_IDLE;
            cfg_ready   <= 1'b1;
            config_we   <= 1'b0;
            mode        <= MODE_CONST;
            const_      <= '0;
            config_data <= '0;
`ifdef REGISTER_MODE_CFG_READBACK_EN
            rd_valid_r  <= 1'b0;
            rd_sel      <= '0;
`endif
        end else begin
            config_we <= 1'b0;
`ifdef REGISTER_MODE_CFG_READBACK_EN
            rd_valid_r <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        if (cfg_write) begin
                            if (in_range) begin
                                case (offset)
                                    OFF_MODE:  mode   <= cfg_wdata[1:0];
                                    OFF_CONST: const_ <= cfg_wdata;
                                    OFF_VALUE: begin
                                        config_data <= cfg_wdata;
                                        config_we   <= 1'b1;
                                        cfg_ready   <= 1'b0;
                                        state       <= ST_LOAD;
                                    end
                                    default: ;
                                endcase
                            end
                        end
`ifdef REGISTER_MODE_CFG_READBACK_EN
                        else begin
                            rd_sel     <= {in_range, offset};
                            rd_valid_r <= 1'b1;
                            cfg_ready  <= 1'b0;
                            state      <= ST_READ;
                        end
`endif
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef REGISTER_MODE_CFG_READBACK_EN
    // Read mux is live during READ so reg_value is sampled in the strobe cycle.
    always_comb begin
        rd_data = '0;
        if (rd_valid_r && rd_sel[2]) begin
            case (rd_sel[1:0])
                OFF_MODE:   rd_data = WIDTH'(mode);
                OFF_CONST:  rd_data = const_;
                OFF_VALUE:  rd_data = reg_value;
                default:    rd_data = WIDTH'(load_count);
            endcase
        end
    end
    assign rd_valid = rd_valid_r;
`else
    assign rd_valid = 1'b0;
    assign rd_data  = '0;
`endif

endmodule

// File: tb/tb_register_mode_cfg.sv
// Self-checking bench for register_mode_cfg (WIDTH=4, ADDR_WIDTH=8, BASE_ADDR=16).
module tb_register_mode_cfg;

    localparam int W    = 4;
    localparam int AW   = 8;
    localparam int BASE = 16;
`ifdef REGISTER_MODE_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          CLK;
    logic          RESETN;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_write;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_wdata;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          stall;
    logic [W-1:0]  reg_value;
    logic [1:0]    mode;
    logic [W-1:0]  const_;
    logic          clk_en;
    logic          config_we;
    logic [W-1:0]  config_data;

    int checks = 0;
    int errors = 0;

    // Reference state: what the block should be holding, in plain integers.
    int m_mode, m_const, m_data, m_loads;

    register_mode_cfg #(.WIDTH(W), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .stall(stall), .reg_value(reg_value),
        .mode(mode), .const_(const_), .clk_en(clk_en),
        .config_we(config_we), .config_data(config_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_steady(input string tag);
        check({tag, ".mode"},  32'(mode), 32'(m_mode));
        check({tag, ".const"}, 32'(const_), 32'(m_const));
        check({tag, ".cdata"}, 32'(config_data), 32'(m_data));
    endtask

    // One transaction: hold the request until accepted, then check cycle N+1
    // and the return to idle.
    task automatic txn(input bit wr, input int addr, input int wd, input string tag);
        int off;
        bit hit;
        bit load_exp;
        bit read_exp;
        int rd_exp;
        int waitc;
        off = addr - BASE;
        hit = (off >= 0) && (off < 4);
        cfg_valid = 1'b1;
        cfg_write = wr;
        cfg_addr  = AW'(addr);
        cfg_wdata = W'(wd);
        waitc = 0;
        while (cfg_ready !== 1'b1 && waitc < 8) begin
            tick();
            waitc++;
        end
        check({tag, ".ready_wait"}, 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        // reg_value changes after the accept edge; a read must see the new one
        reg_value = W'($urandom);

        load_exp = wr && hit && (off == 2);
        read_exp = !wr && RB;
        if (wr && hit) begin
            if (off == 0) m_mode = wd % 4;
            else if (off == 1) m_const = wd % 16;
            else if (off == 2) m_data = wd % 16;
        end
        rd_exp = 0;
        if (read_exp && hit) begin
            if (off == 0) rd_exp = m_mode;
            else if (off == 1) rd_exp = m_const;
            else if (off == 2) rd_exp = int'(reg_value);
            else rd_exp = m_loads % 16;
        end

        check_steady(tag);
        check({tag, ".we"},      32'(config_we), 32'(load_exp));
        check({tag, ".ready"},   32'(cfg_ready), 32'(!(load_exp || read_exp)));
        check({tag, ".rdvalid"}, 32'(rd_valid),  32'(read_exp));
        check({tag, ".rddata"},  32'(rd_data),   32'(rd_exp));
        check({tag, ".clken"},   32'(clk_en),    32'(!stall));

        if (load_exp) m_loads = (m_loads < 255) ? m_loads + 1 : 255;
        if (load_exp || read_exp) begin
            tick();
            check({tag, ".we_end"},    32'(config_we), 32'd0);
            check({tag, ".rd_end"},    32'(rd_valid),  32'd0);
            check({tag, ".ready_end"}, 32'(cfg_ready), 32'd1);
        end
    endtask

    initial begin
        RESETN    = 1'b0;
        cfg_valid = 1'b0;
        cfg_write = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        stall     = 1'b0;
        reg_value = '0;
        m_mode = 0; m_const = 0; m_data = 0; m_loads = 0;

        // Reset state
        tick(); tick(); tick();
        check_steady("rst");
        check("rst.we",      32'(config_we), 32'd0);
        check("rst.rdvalid", 32'(rd_valid),  32'd0);
        check("rst.rddata",  32'(rd_data),   32'd0);
        check("rst.clken",   32'(clk_en),    32'd0);
        check("rst.ready",   32'(cfg_ready), 32'd1);
        RESETN = 1'b1;
        tick();
        check("rel.clken", 32'(clk_en),    32'd1);
        check("rel.ready", 32'(cfg_ready), 32'd1);

        // Stall propagation
        stall = 1'b1;
        tick();
        check("stall.clken", 32'(clk_en), 32'd0);
        stall = 1'b0;
        tick();
        check("unstall.clken", 32'(clk_en), 32'd1);

        // Mode and const writes
        txn(1'b1, BASE + 0, 'h2, "wr_mode");
        txn(1'b1, BASE + 1, 'h9, "wr_const");
        txn(1'b1, BASE + 0, 'hF, "wr_mode_hi");

        // Value write, then a second one held high straight after
        txn(1'b1, BASE + 2, 'hA, "wr_val");
        cfg_valid = 1'b1;
        cfg_write = 1'b1;
        cfg_addr  = AW'(BASE + 2);
        cfg_wdata = 4'h3;
        check("b2b.notyet_we", 32'(config_we), 32'd0);
        txn(1'b1, BASE + 2, 'h3, "wr_val_b2b");

        // Reads of each register
        txn(1'b0, BASE + 0, 0, "rd_mode");
        txn(1'b0, BASE + 1, 0, "rd_const");
        txn(1'b0, BASE + 2, 0, "rd_val");
        txn(1'b0, BASE + 3, 0, "rd_status");

        // Out-of-range and status writes have no effect
        txn(1'b1, BASE + 4, 'h7, "wr_oor");
        txn(1'b1, BASE - 1, 'h7, "wr_below");
        txn(1'b1, BASE + 3, 'h7, "wr_status");
        txn(1'b0, BASE + 4, 0, "rd_oor");

        // Saturate the load counter
        for (int i = 0; i < 260; i++) begin
            txn(1'b1, BASE + 2, i % 16, "sat_wr");
        end
        txn(1'b0, BASE + 3, 0, "rd_sat");

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            stall = 1'($urandom);
            txn(1'($urandom), BASE - 2 + int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), "rand");
        end

        // Reset asserted during the LOAD cycle
        cfg_valid = 1'b1;
        cfg_write = 1'b1;
        cfg_addr  = AW'(BASE + 2);
        cfg_wdata = 4'h6;
        tick();
        cfg_valid = 1'b0;
        check("rstload.we_pre", 32'(config_we), 32'd1);
        RESETN = 1'b0;
        tick();
        m_mode = 0; m_const = 0; m_data = 0; m_loads = 0;
        check("rstload.we",    32'(config_we), 32'd0);
        check("rstload.ready", 32'(cfg_ready), 32'd1);
        check_steady("rstload");
        RESETN = 1'b1;
        tick();
        txn(1'b0, BASE + 3, 0, "rstload_status");
        txn(1'b1, BASE + 2, 'h5, "post_rst_wr");
        txn(1'b0, BASE + 3, 0, "post_rst_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
